// File: rtl/partition_bucket_ctrl.sv
// Hash-join partition bucket controller.
// Tuples are written into per-partition buckets held in an internal
// simple dual-port RAM addressed {part, slot}. A bucket that fills is
// streamed out at once; flush_all drains every non-empty bucket in
// ascending partition order and then pulses flush_done.
module partition_bucket_ctrl #(
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_PART_BITS = 3,
    parameter int SLOT_BITS     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [NUM_PART_BITS-1:0] in_part,
    input  logic                     flush_all,
    output logic                     flush_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [NUM_PART_BITS-1:0] out_part,
    output logic                     out_last
);

    localparam int P  = 1 << NUM_PART_BITS;
    localparam int AW = NUM_PART_BITS + SLOT_BITS;
    localparam logic [SLOT_BITS:0] DEPTH = (SLOT_BITS+1)'(1 << SLOT_BITS);
    localparam logic [SLOT_BITS:0] ONE_C = (SLOT_BITS+1)'(1);
    localparam logic [SLOT_BITS-1:0] ONE_S = SLOT_BITS'(1);
    localparam logic [NUM_PART_BITS-1:0] ONE_P = NUM_PART_BITS'(1);

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]               state;
    logic                     run;
    logic                     pend_all;
    logic                     from_scan;
    logic [SLOT_BITS:0]       cnt [P];
    logic [NUM_PART_BITS-1:0] fpart;
    logic [NUM_PART_BITS-1:0] scan_p;
    logic [SLOT_BITS-1:0]     rd_slot;
    logic [SLOT_BITS:0]       rd_end;

    logic [DATA_WIDTH-1:0]    ram [1 << AW];

    logic                     rd_vld_p1;
    logic [DATA_WIDTH-1:0]    ram_q_p1;
    logic [NUM_PART_BITS-1:0] rd_part_p1;
    logic                     rd_last_p1;

    logic [1:0]               fifo_cnt;
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [DATA_WIDTH-1:0]    fifo_data [2];
    logic [NUM_PART_BITS-1:0] fifo_part [2];
    logic                     fifo_last [2];

    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [SLOT_BITS:0]       cnt_inc;
    logic                     fill;
    logic                     pop;
    logic [2:0]               credit_sum;
    logic                     rd_issue;
    logic                     rd_last;
    logic [AW-1:0]            rd_addr;

    // in_ready stays low for the first cycle after reset and during the flush_done pulse
    assign in_ready = run && (state == ST_ACCEPT) && !pend_all && !flush_done;

    // Write-side and read-side control decode; credit counts this cycle's pop as freeing a slot
    always_comb begin
        wr_en      = in_valid && in_ready;
        wr_addr    = {in_part, cnt[in_part][SLOT_BITS-1:0]};
        cnt_inc    = cnt[in_part] + ONE_C;
        fill       = wr_en && (cnt_inc == DEPTH);
        pop        = out_valid && out_ready;
        credit_sum = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, rd_vld_p1};
        rd_issue   = (state == ST_FLUSH) && (credit_sum < 3'd2);
        rd_last    = ({1'b0, rd_slot} == (rd_end - ONE_C));
        rd_addr    = {fpart, rd_slot};
    end

    // Sequencer: fill counters, bucket flush, scan for non-empty buckets, completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_ACCEPT;
            run        <= 1'b0;
            pend_all   <= 1'b0;
            from_scan  <= 1'b0;
            fpart      <= '0;
            scan_p     <= '0;
            rd_slot    <= '0;
            rd_end     <= '0;
            flush_done <= 1'b0;
            for (int i = 0; i < P; i++) cnt[i] <= '0;
        end else begin
            run        <= 1'b1;
            flush_done <= 1'b0;
            if (flush_all) pend_all <= 1'b1;
            case (state)
                ST_ACCEPT: begin
                    if (wr_en) cnt[in_part] <= cnt_inc;
                    if (fill) begin
                        state     <= ST_FLUSH;
                        fpart     <= in_part;
                        rd_slot   <= '0;
                        rd_end    <= DEPTH;
                        from_scan <= 1'b0;
                    end else if (pend_all || flush_all) begin
                        state  <= ST_SCAN;
                        scan_p <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (rd_issue) begin
                        rd_slot <= rd_slot + ONE_S;
                        if (rd_last) begin
                            cnt[fpart] <= '0;
                            if (!from_scan) begin
                                state <= ST_ACCEPT;
                            end else if (&scan_p) begin
                                state <= ST_FINISH;
                            end else begin
                                state  <= ST_SCAN;
                                scan_p <= scan_p + ONE_P;
                            end
                        end
                    end
                end
                ST_SCAN: begin
                    if (cnt[scan_p] != '0) begin
                        state     <= ST_FLUSH;
                        fpart     <= scan_p;
                        rd_slot   <= '0;
                        rd_end    <= cnt[scan_p];
                        from_scan <= 1'b1;
                    end else if (&scan_p) begin
                        state <= ST_FINISH;
                    end else begin
                        scan_p <= scan_p + ONE_P;
                    end
                end
                ST_FINISH: begin
                    if ((fifo_cnt == 2'd0) && !rd_vld_p1) begin
                        flush_done <= 1'b1;
                        pend_all   <= 1'b0;
                        state      <= ST_ACCEPT;
                    end
                end
                default: state <= ST_ACCEPT;
            endcase
        end
    end

    // Bucket RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= in_data;
    end

    // ---- stage p1: registered RAM read with its partition/last tags ----
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            ram_q_p1   <= ram[rd_addr];
            rd_part_p1 <= fpart;
            rd_last_p1 <= rd_last;
        end
    end

    // Read-in-flight marker travelling with the p1 data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_vld_p1 <= 1'b0;
        else     rd_vld_p1 <= rd_issue;
    end

    // ---- stage p2: two-entry output FIFO; head entry holds still under backpressure ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_part[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (rd_vld_p1) begin
                fifo_data[wr_ptr] <= ram_q_p1;
                fifo_part[wr_ptr] <= rd_part_p1;
                fifo_last[wr_ptr] <= rd_last_p1;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, rd_vld_p1} - {1'b0, pop};
        end
    end

    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_part  = fifo_part[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];

endmodule

// File: doc/partition_bucket_ctrl.md
Name: partition_bucket_ctrl

Overview:
- Controller that sequences a simple dual-port single-clock RAM, instantiated internally, as 2^NUM_PART_BITS per-partition buckets of 2^SLOT_BITS tuples each, for the partitioning phase of the hash join.
- Accepts partitioned tuples, writes them into their bucket, and tracks the fill level of each bucket.
- Streams a bucket out when it becomes full, and drains all non-empty buckets on request.

Parameters:
DATA_WIDTH, 64, tuple width in bits
NUM_PART_BITS, 3, log2 of the partition count P (default P=8)
SLOT_BITS, 3, log2 of the bucket depth D (default D=8); RAM address is {part, slot}

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input tuple valid
in_ready  output  1  controller accepts a tuple
in_data  input  DATA_WIDTH  tuple
in_part  input  NUM_PART_BITS  destination partition
flush_all  input  1  single-cycle request to drain every non-empty bucket
flush_done  output  1  single-cycle pulse when the flush_all drain is complete
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the beat
out_data  output  DATA_WIDTH  tuple read from the bucket
out_part  output  NUM_PART_BITS  partition of the beat
out_last  output  1  final beat of the bucket

Behaviour:
- Reset (async, active-high):
  - Outputs: in_ready=0, out_valid=0, out_last=0, flush_done=0, out_data=0, out_part=0.
  - Internal state: all fill counters cleared, FSM set to ACCEPT, output buffer emptied, pending-flush flag cleared.
  - RAM contents are not cleared.
  - Reset mid-flush abandons the flush; no further beats are emitted.
- Fill counters: one per partition, SLOT_BITS+1 bits wide, range 0..D.
- Handshakes: a transfer occurs when valid && ready is high at a clk edge. out_* are held stable while out_valid=1 && out_ready=0.
- FSM states: ACCEPT, FLUSH, SCAN, FINISH.
- ACCEPT:
  - in_ready=1 unless pend_all is set.
  - On an input handshake: write the RAM at {in_part, cnt[in_part]} and increment cnt[in_part].
  - If the increment reaches D: next state is FLUSH with fpart=in_part, rd_slot=0, rd_end=D.
  - Otherwise, if pend_all is set: next state is SCAN with scan_p=0.
- flush_all:
  - Sampled in any state; sets pend_all.
  - If it coincides with a filling handshake, the full-bucket FLUSH runs first, then SCAN.
  - flush_all while pend_all is already set is ignored.
- FLUSH:
  - in_ready=0.
  - Issue one RAM read of {fpart, rd_slot} per cycle when credit allows; increment rd_slot per issued read.
  - When the read for slot rd_end-1 is issued: clear cnt[fpart] in that cycle; next state is SCAN (continuing at scan_p+1) if the flush came from a scan, otherwise ACCEPT.
- SCAN:
  - in_ready=0.
  - One cycle per partition visited.
  - If cnt[scan_p]==0: advance scan_p.
  - Otherwise: go to FLUSH with fpart=scan_p, rd_end=cnt[scan_p].
  - After partition P-1: go to FINISH.
- FINISH:
  - Wait until the output buffer is empty and no read is in flight.
  - Pulse flush_done for exactly one cycle, clear pend_all, and return to ACCEPT.
- Read pipeline:
  - RAM read latency is 1 cycle; RAM output is captured into a 2-entry output FIFO.
  - A read is issued only if (FIFO occupancy + reads in flight) < 2. This guarantees no overflow under backpressure.
  - Throughput is 1 beat/cycle when out_ready is held high.
- Latency: for a filling handshake at cycle T, reads are issued at T+1..T+D, the first out_valid appears at T+3, and in_ready returns high at T+D+1.
- Output tagging: each read carries fpart and a last flag (slot==rd_end-1) through the pipeline to out_part and out_last.
- Beat order: slot 0 first; partitions drained in ascending order.
- Write/read overlap: a write to a bucket after its counter clears may coincide with the final read; the read data is already registered and is unaffected.

Test Plan:
1. Eight tuples 0x30..0x37 to part 3, out_ready=1, last handshake at T -> in_ready=0 at T+1..T+8 and 1 at T+9; beats 0x30..0x37 at T+3..T+10 with out_part=3 and out_last only on 0x37.
2. Same stimulus with out_ready toggling randomly -> exactly 0x30..0x37 in order; no duplicates or drops; out_* stable while stalled.
3. Part 0 holds 0xA0,0xA1 and part 5 holds 0xB0; pulse flush_all -> beats A0, A1(last), B0(last); single flush_done cycle after B0 is accepted; all counters zero; in_ready=1 afterwards.
4. All buckets empty, flush_all at T -> no out_valid; flush_done at T+10 (SCAN T+1..T+8, FINISH T+9, pulse registered T+10); in_ready low T+1..T+10.
5. flush_all in the same cycle as the 8th handshake to part 1 (part 2 holds 1 tuple) -> part 1's eight beats, then part 2's single beat, then flush_done; part 1 emitted exactly once.
6. rst asserted at the 4th beat of a full-bucket flush -> out_valid=0 and in_ready=0 immediately; after release in_ready=1, counters zero; a new tuple to part 3 does not trigger a flush.
